// File: rtl/enc8_3_seq.sv
// enc8_3_seq: sequential 8-to-3 encoder.
// Accepts a multi-hot 8-bit request vector and emits the index of each set
// bit, one per valid/ready handshake, in priority order.
// LSB_FIRST=1 emits the lowest set index first; LSB_FIRST=0 emits the highest first.
module enc8_3_seq #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] inp,
  input  logic       inp_valid,
  output logic       inp_ready,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       zero_err
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       zero_err_q, zero_err_d;

  logic [2:0] sel_idx;
  logic [7:0] sel_mask;
  logic       one_left;

  // Priority encode of the pending set; the last matching iteration wins,
  // so the scan direction decides which end has priority.
  always_comb begin
    sel_idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_q[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pend_q[i]) sel_idx = 3'(i);
      end
    end
  end

  // Mask of the bit being emitted, and "exactly one bit pending" detect.
  always_comb begin
    sel_mask = 8'd1 << sel_idx;
    one_left = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);
  end

  // Next-state and output decode. Outputs depend only on registered state,
  // so an asynchronous reset drops out_valid without waiting for an edge.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    zero_err_d = 1'b0;
    inp_ready  = 1'b0;
    out_valid  = 1'b0;
    out        = 3'd0;
    out_last   = 1'b0;
    case (state_q)
      IDLE: begin
        inp_ready = 1'b1;
        if (inp_valid) begin
          if (inp != 8'd0) begin
            pend_d  = inp;
            state_d = EMIT;
          end else begin
            // Nothing to emit; flag it for one cycle and stay idle.
            zero_err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out       = sel_idx;
        out_last  = one_left;
        if (out_ready) begin
          pend_d = pend_q & ~sel_mask;
          if (one_left) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 8'd0;
      end
    endcase
  end

  // State, pending-index and error-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= 8'd0;
      zero_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      zero_err_q <= zero_err_d;
    end
  end

  assign zero_err = zero_err_q;

endmodule

// File: tb/tb_enc8_3_seq.sv
// Bench for enc8_3_seq: two instances (LSB-first and MSB-first) driven with
// the same directed vectors, a queue-based reference model compared every
// cycle, plus literal expected sequences per scenario.
module tb_enc8_3_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inp = 8'd0;
  logic       inp_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic       inp_ready1, out_valid1, out_last1, zero_err1;
  logic [2:0] out1;
  logic       inp_ready0, out_valid0, out_last0, zero_err0;
  logic [2:0] out0;

  always #5 clk = ~clk;

  enc8_3_seq #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .inp(inp), .inp_valid(inp_valid), .inp_ready(inp_ready1),
    .out(out1), .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .zero_err(zero_err1)
  );

  enc8_3_seq #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .inp(inp), .inp_valid(inp_valid), .inp_ready(inp_ready0),
    .out(out0), .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .zero_err(zero_err0)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: queue of indices still to be emitted, per build.
  int q1[$];
  int q0[$];
  bit zexp = 1'b0;
  int cyc = 0;

  // Observation logs (handshakes seen at the upcoming edge).
  int log1[$], log0[$], last1[$], last0[$], acc1[$], hs1[$];
  int zcnt1 = 0, zcnt0 = 0;

  task automatic cmp(input string tag, input logic [2:0] o, input logic v, input logic l,
                     input logic r, input logic z, input int sz, input int front, input bit ze);
    check({tag, "_out_valid"}, {31'd0, v}, {31'd0, sz != 0});
    check({tag, "_out"}, {29'd0, o}, (sz != 0) ? front : 0);
    check({tag, "_out_last"}, {31'd0, l}, {31'd0, sz == 1});
    check({tag, "_inp_ready"}, {31'd0, r}, {31'd0, sz == 0});
    check({tag, "_zero_err"}, {31'd0, z}, {31'd0, ze});
  endtask

  // Compare on the falling edge, then advance the model to the state the
  // DUT will hold after the next rising edge.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1.delete();
      q0.delete();
      zexp = 1'b0;
    end else begin
      bit was_empty;
      int f1, f0;
      cyc++;
      f1 = (q1.size() > 0) ? q1[0] : 0;
      f0 = (q0.size() > 0) ? q0[0] : 0;
      cmp("lsb", out1, out_valid1, out_last1, inp_ready1, zero_err1, q1.size(), f1, zexp);
      cmp("msb", out0, out_valid0, out_last0, inp_ready0, zero_err0, q0.size(), f0, zexp);
      if (zero_err1) zcnt1++;
      if (zero_err0) zcnt0++;
      if (out_valid1 && out_ready) begin
        log1.push_back(int'(out1));
        last1.push_back(int'(out_last1));
        hs1.push_back(cyc);
      end
      if (out_valid0 && out_ready) begin
        log0.push_back(int'(out0));
        last0.push_back(int'(out_last0));
      end
      if (inp_valid && inp_ready1) acc1.push_back(cyc);
      was_empty = (q1.size() == 0);
      zexp = 1'b0;
      if (!was_empty && out_ready) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (was_empty && inp_valid) begin
        if (inp == 8'd0) zexp = 1'b1;
        for (int i = 0; i < 8; i++) if (inp[i]) q1.push_back(i);
        for (int i = 7; i >= 0; i--) if (inp[i]) q0.push_back(i);
      end
    end
  end

  task automatic clear_logs();
    log1.delete(); log0.delete(); last1.delete(); last0.delete();
    acc1.delete(); hs1.delete();
    zcnt1 = 0; zcnt0 = 0;
  endtask

  // Present a vector and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] v, input bit keep);
    int n;
    n = 0;
    inp = v;
    inp_valid = 1'b1;
    @(negedge clk);
    while (!inp_ready1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!inp_ready1) check("send_timeout", {31'd0, inp_ready1}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) inp_valid = 1'b0;
  endtask

  // Wait until the model has nothing pending (bounded).
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((q1.size() != 0 || q0.size() != 0) && n < 60);
    check("drain", q1.size() + q0.size(), 0);
  endtask

  // exp holds element i in bits [3*i +: 3].
  task automatic check_seq(input string name, input bit lsb, input int n, input logic [23:0] exp);
    int lq[$];
    lq = lsb ? log1 : log0;
    check({name, "_len"}, lq.size(), n);
    for (int i = 0; i < n && i < lq.size(); i++) begin
      check(name, lq[i], {29'd0, exp[3*i +: 3]});
    end
  endtask

  task automatic check_last(input string name, input bit lsb, input int exp_bits);
    int lq[$];
    int bits;
    lq = lsb ? last1 : last0;
    bits = 0;
    for (int i = 0; i < lq.size() && i < 8; i++) bits |= (lq[i] << i);
    check(name, bits, exp_bits);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] e1, e0;
    logic [10:0] pat;

    // Reset state while rst_n is held low.
    #12;
    check("rst_out_valid", {31'd0, out_valid1}, 0);
    check("rst_inp_ready", {31'd0, inp_ready1}, 1);
    check("rst_out", {29'd0, out1}, 0);
    check("rst_out_last", {31'd0, out_last1}, 0);
    check("rst_zero_err", {31'd0, zero_err1}, 0);
    check("rst_msb_out_valid", {31'd0, out_valid0}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-hot vector: index 4 in the cycle after acceptance, idle after.
    clear_logs();
    out_ready = 1'b1;
    send(8'h10, 1'b0);
    @(negedge clk);
    check("onehot_out", {29'd0, out1}, 4);
    check("onehot_valid", {31'd0, out_valid1}, 1);
    check("onehot_last", {31'd0, out_last1}, 1);
    check("onehot_msb_out", {29'd0, out0}, 4);
    @(negedge clk);
    check("onehot_after_valid", {31'd0, out_valid1}, 0);
    check("onehot_after_ready", {31'd0, inp_ready1}, 1);
    wait_idle();
    $display("txn onehot 0x10 done");

    // Multi-hot 0xA5.
    clear_logs();
    send(8'hA5, 1'b0);
    wait_idle();
    check_seq("a5_lsb", 1'b1, 4, {12'd0, 3'd7, 3'd5, 3'd2, 3'd0});
    check_seq("a5_msb", 1'b0, 4, {12'd0, 3'd0, 3'd2, 3'd5, 3'd7});
    check_last("a5_lsb_last", 1'b1, 8);
    check_last("a5_msb_last", 1'b0, 8);
    $display("txn multihot 0xA5 done");

    // 0xFF with backpressure pattern 1,0,0,1,1,0,1,1,1,1,1 and a stray inp_valid.
    clear_logs();
    pat = 11'b11111011001;
    send(8'hFF, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      out_ready = pat[i];
      if (i == 4) begin
        inp = 8'h3C;
        inp_valid = 1'b1;
      end
      if (i == 5) inp_valid = 1'b0;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();
    e1 = '0;
    e0 = '0;
    for (int i = 0; i < 8; i++) begin
      e1[3*i +: 3] = 3'(i);
      e0[3*i +: 3] = 3'(7 - i);
    end
    check_seq("ff_lsb", 1'b1, 8, e1);
    check_seq("ff_msb", 1'b0, 8, e0);
    check("ff_accepts", acc1.size(), 1);
    check_last("ff_lsb_last", 1'b1, 128);
    $display("txn backpressure 0xFF done");

    // Zero vector: one-cycle zero_err, no output.
    clear_logs();
    send(8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_pulse_lsb", zcnt1, 1);
    check("zero_pulse_msb", zcnt0, 1);
    check("zero_no_out", log1.size() + log0.size(), 0);
    $display("txn zero vector done");

    // Asynchronous reset after two handshakes of 0xF0.
    clear_logs();
    send(8'hF0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid_lsb", {31'd0, out_valid1}, 0);
    check("arst_valid_msb", {31'd0, out_valid0}, 0);
    check("arst_ready", {31'd0, inp_ready1}, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_seq("arst_lsb", 1'b1, 2, {18'd0, 3'd5, 3'd4});
    check_seq("arst_msb", 1'b0, 2, {18'd0, 3'd6, 3'd7});
    clear_logs();
    send(8'h02, 1'b0);
    wait_idle();
    check_seq("arst_new_lsb", 1'b1, 1, 24'd1);
    check_seq("arst_new_msb", 1'b0, 1, 24'd1);
    $display("txn reset mid-operation done");

    // Back-to-back 0x81 then 0x18 with inp_valid held high.
    clear_logs();
    send(8'h81, 1'b1);
    send(8'h18, 1'b0);
    wait_idle();
    check_seq("b2b_lsb", 1'b1, 4, {12'd0, 3'd4, 3'd3, 3'd7, 3'd0});
    check_seq("b2b_msb", 1'b0, 4, {12'd0, 3'd3, 3'd4, 3'd0, 3'd7});
    check("b2b_accepts", acc1.size(), 2);
    if (acc1.size() == 2 && hs1.size() == 4) begin
      check("b2b_accept_gap", acc1[1] - acc1[0], 3);
      check("b2b_accept_after_last", acc1[1], hs1[1] + 1);
      check("b2b_idle_cycle", hs1[2] - hs1[1], 2);
    end else begin
      check("b2b_log_sizes", acc1.size() * 10 + hs1.size(), 24);
    end
    $display("txn back-to-back done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
